// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices, R1 layout,
// data token and FSM state encoding.
package sd_spi_pkg;

    localparam logic [5:0] CmdGoIdle     = 6'd0;
    localparam logic [5:0] CmdSendIfCond = 6'd8;
    localparam logic [5:0] CmdReadSingle = 6'd17;
    localparam logic [5:0] CmdSdSendOp   = 6'd41;
    localparam logic [5:0] CmdAppCmd     = 6'd55;
    localparam logic [5:0] CmdReadOcr    = 6'd58;

    localparam int unsigned R1IdleBit    = 0;
    localparam int unsigned R1IllegalBit = 2;

    localparam logic [7:0] TokenStartBlock = 8'hFE;
    localparam logic [7:0] Cmd8Check       = 8'hAA;

    localparam logic [3:0] StWaitCmd   = 4'd0;
    localparam logic [3:0] StCmdArgs   = 4'd1;
    localparam logic [3:0] StNcr       = 4'd2;
    localparam logic [3:0] StSendR1    = 4'd3;
    localparam logic [3:0] StSendTail  = 4'd4;
    localparam logic [3:0] StNac       = 4'd5;
    localparam logic [3:0] StSendToken = 4'd6;
    localparam logic [3:0] StSendData  = 4'd7;
    localparam logic [3:0] StSendCrc   = 4'd8;

    // Byte n (0..3) of the R7 (CMD8) or OCR (CMD58) response tail.
    function automatic logic [7:0] tail_byte(input logic [5:0]  cmd,
                                             input logic [11:0] arg,
                                             input logic        ready,
                                             input logic [1:0]  n);
        logic [7:0] b;
        b = 8'hFF;
        if (cmd == CmdSendIfCond) begin
            case (n)
                2'd0:    b = 8'h00;
                2'd1:    b = 8'h00;
                2'd2:    b = {4'h0, arg[11:8]};
                default: b = arg[7:0];
            endcase
        end else begin
            case (n)
                2'd0:    b = {ready, 1'b1, 6'b0};
                2'd1:    b = 8'hFF;
                2'd2:    b = 8'h80;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/sd_card_responder_if.sv
// Sector byte-fetch bus between the card responder (master) and its byte source (slave).
interface sd_card_responder_if;

    logic [31:0] sector_addr;
    logic        byte_req;
    logic [8:0]  byte_idx;
    logic        byte_ack;
    logic [7:0]  byte_in;

    modport master (
        output sector_addr, byte_req, byte_idx,
        input  byte_ack, byte_in
    );

    modport slave (
        input  sector_addr, byte_req, byte_idx,
        output byte_ack, byte_in
    );

endinterface

// File: rtl/sd_spi_slave_shifter.sv
// Oversampled SPI mode-0 slave bit engine: synchronizers, edge detection, rx/tx shifters
// and the per-byte strobe.
module sd_spi_slave_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_di,
    input  logic       spi_cs,
    input  logic [7:0] tx_next,
    output logic       spi_do,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       cs_active
);

    logic [2:0] clk_sync_q;
    logic [1:0] di_sync_q;
    logic [1:0] cs_sync_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic       load_pending_q;
    logic       do_q;
    logic       sclk_rise;
    logic       sclk_fall;

    assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];
    assign cs_active = ~cs_sync_q[1];
    // Raw chip select forces MISO high without waiting for the synchronizer.
    assign spi_do    = do_q | spi_cs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q     <= '0;
            di_sync_q      <= '0;
            cs_sync_q      <= 2'b11;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_byte        <= '0;
            byte_strobe    <= 1'b0;
            tx_shift_q     <= 8'hFF;
            load_pending_q <= 1'b0;
            do_q           <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], spi_clk};
            di_sync_q   <= {di_sync_q[0], spi_di};
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
            byte_strobe <= 1'b0;
            if (cs_sync_q[1]) begin
                bit_cnt_q      <= '0;
                load_pending_q <= 1'b0;
                tx_shift_q     <= 8'hFF;
                do_q           <= 1'b1;
            end else begin
                if (sclk_rise) begin
                    rx_shift_q <= {rx_shift_q[6:0], di_sync_q[1]};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte        <= {rx_shift_q[6:0], di_sync_q[1]};
                        byte_strobe    <= 1'b1;
                        load_pending_q <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (load_pending_q) begin
                        tx_shift_q     <= tx_next;
                        do_q           <= tx_next[7];
                        load_pending_q <= 1'b0;
                    end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b1};
                        do_q       <= tx_shift_q[6];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_card_responder.sv
// SPI-mode SD card model: answers the init sequence and CMD17 single-block reads, pulling
// sector bytes from an external byte source one byte ahead of transmission.
module sd_card_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned P_NCR         = 1,
    parameter int unsigned P_NAC         = 2,
    parameter int unsigned P_ACMD41_BUSY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_clk,
    input  logic                       spi_di,
    input  logic                       spi_cs,
    output logic                       spi_do,
    sd_card_responder_if.master        bus,
    output logic                       card_ready,
    output logic                       underrun
);

    logic [7:0]  rx_byte;
    logic        byte_strobe;
    logic        cs_active;

    logic [3:0]  state_q, state_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  r1_q, r1_d;
    logic        has_tail_q, has_tail_d;
    logic        has_data_q, has_data_d;
    logic [8:0]  data_idx_q, data_idx_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic [7:0]  tx_next_q, tx_next_d;
    logic        idle_q, idle_d;
    logic        app_q, app_d;
    logic [7:0]  acmd_cnt_q, acmd_cnt_d;
    logic        card_ready_q, card_ready_d;
    logic        underrun_q, underrun_d;
    logic [31:0] sector_addr_q, sector_addr_d;
    logic        byte_req_q, byte_req_d;
    logic [8:0]  byte_idx_q, byte_idx_d;
    logic        illegal;
    logic        idle_n;

    sd_spi_slave_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_di      (spi_di),
        .spi_cs      (spi_cs),
        .tx_next     (tx_next_q),
        .spi_do      (spi_do),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .cs_active   (cs_active)
    );

    assign bus.sector_addr = sector_addr_q;
    assign bus.byte_req    = byte_req_q;
    assign bus.byte_idx    = byte_idx_q;
    assign card_ready      = card_ready_q;
    assign underrun        = underrun_q;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        arg_d         = arg_q;
        cnt_d         = cnt_q;
        r1_d          = r1_q;
        has_tail_d    = has_tail_q;
        has_data_d    = has_data_q;
        data_idx_d    = data_idx_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        tx_next_d     = tx_next_q;
        idle_d        = idle_q;
        app_d         = app_q;
        acmd_cnt_d    = acmd_cnt_q;
        card_ready_d  = card_ready_q;
        underrun_d    = underrun_q;
        sector_addr_d = sector_addr_q;
        byte_req_d    = 1'b0;
        byte_idx_d    = byte_idx_q;
        illegal       = 1'b0;
        idle_n        = idle_q;

        if (!cs_active) begin
            state_d      = StWaitCmd;
            tx_next_d    = 8'hFF;
            hold_valid_d = 1'b0;
        end else begin
            if (byte_strobe) begin
                tx_next_d = 8'hFF;
                case (state_q)
                    StWaitCmd: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_d   = rx_byte[5:0];
                            cnt_d   = 8'd0;
                            state_d = StCmdArgs;
                        end
                    end
                    StCmdArgs: begin
                        if (cnt_q < 8'd4) begin
                            arg_d = {arg_q[23:0], rx_byte};
                            cnt_d = cnt_q + 8'd1;
                        end else begin
                            // CRC byte received (ignored): execute the command.
                            has_tail_d = 1'b0;
                            has_data_d = 1'b0;
                            case (cmd_q)
                                CmdGoIdle: begin
                                    idle_n       = 1'b1;
                                    card_ready_d = 1'b0;
                                    acmd_cnt_d   = 8'd0;
                                    underrun_d   = 1'b0;
                                end
                                CmdSendIfCond: has_tail_d = 1'b1;
                                CmdAppCmd:     ;
                                CmdSdSendOp: begin
                                    if (!app_q) begin
                                        illegal = 1'b1;
                                    end else if (acmd_cnt_q < 8'(P_ACMD41_BUSY)) begin
                                        acmd_cnt_d = acmd_cnt_q + 8'd1;
                                    end else begin
                                        idle_n       = 1'b0;
                                        card_ready_d = 1'b1;
                                    end
                                end
                                CmdReadOcr: has_tail_d = 1'b1;
                                CmdReadSingle: begin
                                    if (card_ready_q) begin
                                        sector_addr_d = arg_q;
                                        has_data_d    = 1'b1;
                                    end else begin
                                        illegal = 1'b1;
                                    end
                                end
                                default: illegal = 1'b1;
                            endcase
                            app_d              = (cmd_q == CmdAppCmd);
                            idle_d             = idle_n;
                            r1_d               = 8'h00;
                            r1_d[R1IllegalBit] = illegal;
                            r1_d[R1IdleBit]    = idle_n;
                            cnt_d              = 8'd1;
                            state_d            = StNcr;
                        end
                    end
                    StNcr: begin
                        if (cnt_q >= 8'(P_NCR)) begin
                            tx_next_d = r1_q;
                            state_d   = StSendR1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    StSendR1: begin
                        cnt_d = 8'd1;
                        if (has_tail_q) begin
                            tx_next_d = tail_byte(cmd_q, arg_q[11:0], card_ready_q, 2'd0);
                            state_d   = StSendTail;
                        end else if (has_data_q) begin
                            state_d = StNac;
                        end else begin
                            state_d = StWaitCmd;
                        end
                    end
                    StSendTail: begin
                        if (cnt_q >= 8'd4) begin
                            state_d = StWaitCmd;
                        end else begin
                            tx_next_d = tail_byte(cmd_q, arg_q[11:0], card_ready_q, cnt_q[1:0]);
                            cnt_d     = cnt_q + 8'd1;
                        end
                    end
                    StNac: begin
                        if (cnt_q >= 8'(P_NAC)) begin
                            tx_next_d    = TokenStartBlock;
                            byte_req_d   = 1'b1;
                            byte_idx_d   = 9'd0;
                            hold_valid_d = 1'b0;
                            state_d      = StSendToken;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    StSendToken, StSendData: begin
                        if (state_q == StSendData && data_idx_q == 9'd511) begin
                            cnt_d   = 8'd1;
                            state_d = StSendCrc;
                        end else begin
                            // Load the next data byte and request the one after it.
                            data_idx_d = (state_q == StSendToken) ? 9'd0 : data_idx_q + 9'd1;
                            if (hold_valid_q) begin
                                tx_next_d = hold_data_q;
                            end else begin
                                tx_next_d  = 8'h00;
                                underrun_d = 1'b1;
                            end
                            hold_valid_d = 1'b0;
                            if (data_idx_d != 9'd511) begin
                                byte_req_d = 1'b1;
                                byte_idx_d = data_idx_d + 9'd1;
                            end
                            state_d = StSendData;
                        end
                    end
                    StSendCrc: begin
                        if (cnt_q >= 8'd2) begin
                            state_d = StWaitCmd;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    default: state_d = StWaitCmd;
                endcase
            end
            // An ack landing on a load strobe belongs to the following byte.
            if (bus.byte_ack && (state_q == StSendToken || state_q == StSendData)) begin
                hold_valid_d = 1'b1;
                hold_data_d  = bus.byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StWaitCmd;
            cmd_q         <= '0;
            arg_q         <= '0;
            cnt_q         <= '0;
            r1_q          <= 8'hFF;
            has_tail_q    <= 1'b0;
            has_data_q    <= 1'b0;
            data_idx_q    <= '0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            tx_next_q     <= 8'hFF;
            idle_q        <= 1'b1;
            app_q         <= 1'b0;
            acmd_cnt_q    <= '0;
            card_ready_q  <= 1'b0;
            underrun_q    <= 1'b0;
            sector_addr_q <= '0;
            byte_req_q    <= 1'b0;
            byte_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            cnt_q         <= cnt_d;
            r1_q          <= r1_d;
            has_tail_q    <= has_tail_d;
            has_data_q    <= has_data_d;
            data_idx_q    <= data_idx_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            tx_next_q     <= tx_next_d;
            idle_q        <= idle_d;
            app_q         <= app_d;
            acmd_cnt_q    <= acmd_cnt_d;
            card_ready_q  <= card_ready_d;
            underrun_q    <= underrun_d;
            sector_addr_q <= sector_addr_d;
            byte_req_q    <= byte_req_d;
            byte_idx_q    <= byte_idx_d;
        end
    end

endmodule

// File: tb/tb_sd_card_responder.sv
// Host-side bench for sd_card_responder: drives SPI commands, supplies sector bytes and
// compares every MISO byte against a command-level card model.
module tb_sd_card_responder;
    import sd_spi_pkg::*;

    localparam int unsigned NCR  = 1;
    localparam int unsigned NAC  = 2;
    localparam int unsigned BUSY = 2;
    localparam int          HALF = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_di = 1'b1;
    logic spi_cs = 1'b1;
    logic spi_do;
    logic card_ready;
    logic underrun;

    sd_card_responder_if bus ();

    sd_card_responder #(
        .P_NCR         (NCR),
        .P_NAC         (NAC),
        .P_ACMD41_BUSY (BUSY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_di     (spi_di),
        .spi_cs     (spi_cs),
        .spi_do     (spi_do),
        .bus        (bus),
        .card_ready (card_ready),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Card model state
    bit          m_idle = 1'b1;
    bit          m_app = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_underrun = 1'b0;
    int          m_cnt = 0;
    logic [7:0]  exp_q[$];
    bit          exp_data;

    // Byte source control
    int          withhold_idx = -1;
    int          ack_delay = 3;
    logic [7:0]  data_key = 8'h00;
    int          req_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_app = 1'b0;
        m_ready = 1'b0;
        m_underrun = 1'b0;
        m_cnt = 0;
    endtask

    // Expected R1 (+ tail) for a command, applying its effect on the card state.
    task automatic model_cmd(input logic [5:0] cmd, input logic [31:0] arg);
        bit ill;
        ill = 1'b0;
        exp_q.delete();
        exp_data = 1'b0;
        case (cmd)
            6'd0: begin
                m_idle = 1'b1;
                m_ready = 1'b0;
                m_cnt = 0;
                m_underrun = 1'b0;
            end
            6'd8, 6'd55, 6'd58: ;
            6'd41: begin
                if (!m_app) ill = 1'b1;
                else if (m_cnt < BUSY) m_cnt++;
                else begin
                    m_idle = 1'b0;
                    m_ready = 1'b1;
                end
            end
            6'd17: begin
                if (m_ready) exp_data = 1'b1;
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        m_app = (cmd == 6'd55);
        if (ill) exp_q.push_back(m_idle ? 8'h05 : 8'h04);
        else exp_q.push_back(m_idle ? 8'h01 : 8'h00);
        if (!ill && cmd == 6'd8) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back({4'h0, arg[11:8]});
            exp_q.push_back(arg[7:0]);
        end
        if (cmd == 6'd58) begin
            exp_q.push_back(m_ready ? 8'hC0 : 8'h40);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'h80);
            exp_q.push_back(8'h00);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_di = tx[i];
            #(HALF);
            rx = {rx[6:0], spi_do};
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        check_value({tag, "_spi_do"}, 32'(spi_do), 32'd1);
        check_value({tag, "_byte_req"}, 32'(bus.byte_req), 32'd0);
        check_value({tag, "_byte_idx"}, 32'(bus.byte_idx), 32'd0);
        check_value({tag, "_sector_addr"}, bus.sector_addr, 32'd0);
        check_value({tag, "_card_ready"}, 32'(card_ready), 32'd0);
        check_value({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    task automatic abort_link(input int kind);
        if (kind == 1) begin
            spi_cs = 1'b1;
            repeat (4) @(negedge clk);
            check_value("cs_high_spi_do", 32'(spi_do), 32'd1);
            repeat (8) @(negedge clk);
        end else begin
            @(negedge clk);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            check_reset("mid_reset");
            spi_cs = 1'b1;
            rst_n = 1'b1;
            model_reset();
            repeat (8) @(negedge clk);
        end
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // abort_at: data byte index at which the read is cut (-1 none); kind 1 = cs, 2 = reset.
    task automatic do_cmd(input logic [5:0] cmd, input logic [31:0] arg,
                          input int abort_at, input int abort_kind);
        logic [7:0] frame[6];
        logic [7:0] r;
        logic [7:0] exp;
        int         bad;
        bit         aborted;
        @(negedge clk);
        model_cmd(cmd, arg);
        frame[0] = {2'b01, cmd};
        frame[1] = arg[31:24];
        frame[2] = arg[23:16];
        frame[3] = arg[15:8];
        frame[4] = arg[7:0];
        frame[5] = (cmd == 6'd0) ? 8'h95 : (cmd == 6'd8) ? 8'h87 : (8'($urandom) | 8'h01);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            xfer(frame[i], r);
            if (r !== 8'hFF) bad++;
        end
        for (int i = 0; i < int'(NCR); i++) begin
            xfer(8'hFF, r);
            if (r !== 8'hFF) bad++;
        end
        check_value($sformatf("cmd%0d_fill_ff_bad", cmd), bad, 0);
        foreach (exp_q[i]) begin
            xfer(8'hFF, r);
            check_value($sformatf("cmd%0d_resp%0d", cmd, i), 32'(r), 32'(exp_q[i]));
        end
        aborted = 1'b0;
        if (exp_data) begin
            req_cnt = 0;
            bad = 0;
            for (int i = 0; i < int'(NAC); i++) begin
                xfer(8'hFF, r);
                if (r !== 8'hFF) bad++;
            end
            check_value("nac_ff_bad", bad, 0);
            xfer(8'hFF, r);
            check_value("token", 32'(r), 32'h0000_00FE);
            for (int i = 0; i < 512 && !aborted; i++) begin
                if (i == abort_at) begin
                    aborted = 1'b1;
                    abort_link(abort_kind);
                end else begin
                    xfer(8'hFF, r);
                    if (i == withhold_idx) begin
                        exp = 8'h00;
                        m_underrun = 1'b1;
                    end else begin
                        exp = 8'(i) ^ 8'h5A ^ data_key;
                    end
                    check_value($sformatf("data%0d", i), 32'(r), 32'(exp));
                end
            end
            if (!aborted) begin
                bad = 0;
                for (int i = 0; i < 2; i++) begin
                    xfer(8'hFF, r);
                    if (r !== 8'hFF) bad++;
                end
                check_value("crc_ff_bad", bad, 0);
                check_value("byte_req_count", req_cnt, 512);
            end
            if (abort_kind != 2) check_value("sector_addr", bus.sector_addr, arg);
        end
        if (!aborted) begin
            xfer(8'hFF, r);
            check_value($sformatf("cmd%0d_trail_ff", cmd), 32'(r), 32'h0000_00FF);
        end
        check_value("card_ready", 32'(card_ready), 32'(m_ready));
        check_value("underrun", 32'(underrun), 32'(m_underrun));
    endtask

    // Sector byte source
    initial begin
        int idx;
        bus.byte_ack = 1'b0;
        bus.byte_in = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.byte_req === 1'b1) begin
                idx = int'(bus.byte_idx);
                req_cnt++;
                repeat (ack_delay) @(negedge clk);
                if (idx != withhold_idx) begin
                    bus.byte_in = 8'(idx) ^ 8'h5A ^ data_key;
                    bus.byte_ack = 1'b1;
                    @(negedge clk);
                    bus.byte_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rc;
        repeat (4) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);

        do_cmd(6'd0, 32'h0, -1, 0);
        do_cmd(6'd17, 32'h123, -1, 0);
        do_cmd(6'd1, 32'h0, -1, 0);
        do_cmd(6'd41, 32'h4000_0000, -1, 0);
        do_cmd(6'd8, {20'h0, 4'h1, Cmd8Check}, -1, 0);
        do_cmd(6'd8, $urandom, -1, 0);
        repeat (3) begin
            do_cmd(6'd55, 32'h0, -1, 0);
            do_cmd(6'd41, 32'h4000_0000, -1, 0);
        end
        do_cmd(6'd58, 32'h0, -1, 0);
        do_cmd(6'd17, 32'h123, -1, 0);

        data_key = 8'($urandom);
        ack_delay = $urandom_range(1, 6);
        withhold_idx = 10;
        do_cmd(6'd17, $urandom, 20, 1);
        withhold_idx = -1;
        do_cmd(6'd17, $urandom, 100, 1);
        do_cmd(6'd58, 32'h0, -1, 0);
        do_cmd(6'd17, $urandom, 50, 2);
        do_cmd(6'd0, 32'h0, -1, 0);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 6))
                0: rc = 6'd0;
                1: rc = 6'd8;
                2: rc = 6'd55;
                3: rc = 6'd41;
                4: rc = 6'd58;
                5: rc = 6'd17;
                default: rc = 6'($urandom);
            endcase
            ack_delay = $urandom_range(1, 6);
            do_cmd(rc, $urandom, $urandom_range(5, 20), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
